uart_word_bridge: RTL and testbench

Sits between the byte-level UART receiver/transmitter and the command interpreter. Buffers received bytes and packs them little-endian into 32-bit command words served on the interpreter's uart_read/uart_response handshake. Takes 32-bit response words on uart_write and serialises them as 4 bytes, LSB first, to the UART transmitter. It is the responder end of the interpreter's word-level UART interface.

---
 rtl/uart_word_bridge_pkg.sv | 34 +++
 rtl/uart_word_bridge_if.sv | 35 +++
 rtl/uart_word_bridge_byte_fifo.sv | 50 +++++
 rtl/uart_word_bridge.sv | 125 ++++++++++++
 tb/tb_uart_word_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_word_bridge_pkg.sv
// Shared types and helpers for the UART word bridge.
// Holds the FSM encoding and little-endian byte-lane access.
package uart_bridge_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_POP,
      S_RD_RESP,
      S_WR_SEND,
      S_WR_RESP,
      S_RELEASE
   } state_t;

   function automatic logic [7:0] byte_lane(
      input logic [31:0] w,
      input logic [1:0]  i
   );
      return w[{i, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] set_lane(
      input logic [31:0] w,
      input logic [1:0]  i,
      input logic [7:0]  b
   );
      logic [31:0] r;
      r = w;
      r[{i, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/uart_word_bridge_if.sv
// Byte-side and word-side signals of the UART word bridge.
// slave is the bridge; master is the UART PHY plus interpreter.
interface uart_word_bridge_if;

   logic        rx_byte_valid;
   logic [7:0]  rx_byte;
   logic [7:0]  tx_byte;
   logic        tx_byte_valid;
   logic        tx_byte_ready;
   logic        uart_rx_empty;
   logic        uart_tx_empty;
   logic        uart_read;
   logic        uart_write;
   logic [31:0] uart_write_data;
   logic [31:0] uart_read_data;
   logic        uart_response;
   logic        rx_overflow;

   modport slave (
      input  rx_byte_valid, rx_byte, tx_byte_ready,
      input  uart_read, uart_write, uart_write_data,
      output tx_byte, tx_byte_valid,
      output uart_rx_empty, uart_tx_empty,
      output uart_read_data, uart_response, rx_overflow
   );

   modport master (
      output rx_byte_valid, rx_byte, tx_byte_ready,
      output uart_read, uart_write, uart_write_data,
      input  tx_byte, tx_byte_valid,
      input  uart_rx_empty, uart_tx_empty,
      input  uart_read_data, uart_response, rx_overflow
   );

endinterface

// File: rtl/uart_word_bridge_byte_fifo.sv
// Synchronous byte FIFO with a combinational head output.
// A pop frees a slot, so push+pop is accepted even when full.
module byte_fifo #(
   parameter  int DEPTH    = 16,
   parameter  int WIDTH    = 8,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic [WIDTH-1:0]    din,
   input  logic                pop,
   output logic [WIDTH-1:0]    dout,
   output logic [PTR_BITS:0]   count,
   output logic                full
);

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == (PTR_BITS+1)'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // pointers wrap naturally; count tracks occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   // storage needs no reset; count guards reads
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_word_bridge.sv
// Packs RX bytes into 32-bit command words and serialises
// 32-bit response words to the UART transmitter, LSB first.
module uart_word_bridge
   import uart_bridge_pkg::*;
#(
   parameter  int RX_FIFO_DEPTH = 16,
   localparam int RX_PTR_BITS   = $clog2(RX_FIFO_DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   uart_word_bridge_if.slave bus
);

   state_t               state;
   state_t               next_state;
   logic [1:0]           idx;
   logic [31:0]          word;
   logic [31:0]          read_data;
   logic                 response;
   logic                 overflow;
   logic [7:0]           head;
   logic [RX_PTR_BITS:0] count;
   logic                 full;
   logic                 pop;
   logic                 last;
   logic                 have_word;
   logic                 read_go;
   logic                 tx_hs;

   byte_fifo #(
      .DEPTH (RX_FIFO_DEPTH),
      .WIDTH (8)
   ) rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.rx_byte_valid),
      .din   (bus.rx_byte),
      .pop   (pop),
      .dout  (head),
      .count (count),
      .full  (full)
   );

   assign last      = (idx == 2'(WORD_BYTES - 1));
   assign have_word = (count >= (RX_PTR_BITS+1)'(WORD_BYTES));
   assign read_go   = bus.uart_read && have_word;
   assign tx_hs     = (state == S_WR_SEND) && bus.tx_byte_ready;

   // next state; reads win over writes, RELEASE waits for both levels low
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (read_go)
               next_state = S_RD_POP;
            else if (bus.uart_write)
               next_state = S_WR_SEND;
         end
         S_RD_POP: begin
            pop = 1'b1;
            if (last) next_state = S_RD_RESP;
         end
         S_RD_RESP: next_state = S_RELEASE;
         S_WR_SEND: begin
            if (tx_hs && last) next_state = S_WR_RESP;
         end
         S_WR_RESP: next_state = S_RELEASE;
         S_RELEASE: begin
            if (!bus.uart_read && !bus.uart_write)
               next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   // byte index, word assembly/latch, response pulse, sticky overflow
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx       <= '0;
         word      <= '0;
         read_data <= '0;
         response  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         response <= (next_state == S_RD_RESP) ||
                     (next_state == S_WR_RESP);
         if (bus.rx_byte_valid && full && !pop)
            overflow <= 1'b1;
         case (state)
            S_IDLE: begin
               idx <= '0;
               if (!read_go && bus.uart_write)
                  word <= bus.uart_write_data;
            end
            S_RD_POP: begin
               word <= set_lane(word, idx, head);
               idx  <= idx + 1'b1;
               if (last)
                  read_data <= set_lane(word, idx, head);
            end
            S_WR_SEND: begin
               if (tx_hs) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.tx_byte_valid  = (state == S_WR_SEND);
   assign bus.tx_byte        = bus.tx_byte_valid ?
                               byte_lane(word, idx) : 8'h00;
   assign bus.uart_rx_empty  = !have_word;
   assign bus.uart_tx_empty  = (state == S_IDLE);
   assign bus.uart_read_data = read_data;
   assign bus.uart_response  = response;
   assign bus.rx_overflow    = overflow;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Self-checking bench for uart_word_bridge: transaction model
// compared every cycle, plus directed literal expectations.
module tb_uart_word_bridge;

   logic clk = 1'b0;
   logic reset;

   uart_word_bridge_if bus ();

   uart_word_bridge #(
      .RX_FIFO_DEPTH (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h",
                  name, $time, act, exp);
      end
   endtask

   // ---- transaction-level model ----
   logic [7:0]  mq[$];
   logic [7:0]  mtx[$];
   int          mphase = 0;
   int          mcnt = 0;
   logic [31:0] mword = '0;
   logic [31:0] mrd = '0;
   logic        mresp = 1'b0;
   logic        movf = 1'b0;

   // phases: 0 idle, 1 reading, 2 sending, 3 responding, 4 release
   always @(posedge clk) begin
      int n;
      logic [31:0] w;
      if (!reset) begin
         mq.delete();
         mtx.delete();
         mphase = 0;
         mcnt   = 0;
         mrd    = '0;
         mresp  = 1'b0;
         movf   = 1'b0;
      end else begin
         n     = mq.size();
         mresp = 1'b0;
         case (mphase)
            0: begin
               if (bus.uart_read && n >= 4) begin
                  w = '0;
                  for (int k = 0; k < 4; k++)
                     w = {mq.pop_front(), w[31:8]};
                  mword  = w;
                  mcnt   = 4;
                  mphase = 1;
               end else if (bus.uart_write) begin
                  mtx.delete();
                  w = bus.uart_write_data;
                  for (int k = 0; k < 4; k++) begin
                     mtx.push_back(w[7:0]);
                     w = w >> 8;
                  end
                  mphase = 2;
               end
            end
            1: begin
               mcnt--;
               if (mcnt == 0) begin
                  mresp  = 1'b1;
                  mrd    = mword;
                  mphase = 3;
               end
            end
            2: begin
               if (bus.tx_byte_ready) begin
                  void'(mtx.pop_front());
                  if (mtx.size() == 0) begin
                     mresp  = 1'b1;
                     mphase = 3;
                  end
               end
            end
            3: mphase = 4;
            4: if (!bus.uart_read && !bus.uart_write) mphase = 0;
            default: mphase = 0;
         endcase
         if (bus.rx_byte_valid) begin
            if (n < 16) mq.push_back(bus.rx_byte);
            else        movf = 1'b1;
         end
      end
   end

   // ---- per-cycle compare ----
   initial begin
      int pend;
      @(posedge clk);
      forever begin
         @(negedge clk);
         pend = (mphase == 1) ? mcnt : 0;
         chk("uart_response", 32'(bus.uart_response), 32'(mresp));
         chk("uart_read_data", bus.uart_read_data, mrd);
         chk("tx_byte_valid", 32'(bus.tx_byte_valid),
             32'(mphase == 2));
         if (mphase == 2)
            chk("tx_byte", 32'(bus.tx_byte), 32'(mtx[0]));
         chk("uart_rx_empty", 32'(bus.uart_rx_empty),
             32'((mq.size() + pend) < 4));
         chk("uart_tx_empty", 32'(bus.uart_tx_empty),
             32'(mphase == 0));
         chk("rx_overflow", 32'(bus.rx_overflow), 32'(movf));
      end
   end

   // ---- stimulus helpers ----
   logic [7:0] next_byte;
   logic [7:0] txlog [4];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.rx_byte_valid = 1'b1;
      bus.rx_byte       = b;
      tick();
      bus.rx_byte_valid = 1'b0;
   endtask

   task automatic do_read(input bit feed,
                          output logic [31:0] word,
                          output int lat);
      lat = -1;
      bus.uart_read = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.rx_byte_valid = feed && (i >= 1) && (i <= 4);
         if (bus.rx_byte_valid) begin
            bus.rx_byte = next_byte;
            next_byte++;
         end
         tick();
         if (bus.uart_response) begin
            lat = i + 1;
            break;
         end
      end
      bus.rx_byte_valid = 1'b0;
      word = bus.uart_read_data;
      bus.uart_read = 1'b0;
      tick();
      tick();
      checks++;
      if (lat < 0) begin
         errors++;
         $display("FAIL read_timeout: got no response, expected one");
      end
   endtask

   task automatic do_write(input logic [31:0] data,
                           input int stall_idx,
                           input int stall_n,
                           output int lat,
                           output int sent);
      int stalls;
      stalls = stall_n;
      sent   = 0;
      lat    = -1;
      bus.uart_write      = 1'b1;
      bus.uart_write_data = data;
      for (int i = 0; i < 30; i++) begin
         if (bus.tx_byte_valid && sent == stall_idx && stalls > 0) begin
            bus.tx_byte_ready = 1'b0;
            stalls--;
         end else begin
            bus.tx_byte_ready = 1'b1;
         end
         if (bus.tx_byte_valid && bus.tx_byte_ready) begin
            if (sent < 4) txlog[sent] = bus.tx_byte;
            sent++;
         end
         tick();
         if (bus.uart_response) begin
            lat = i + 1;
            break;
         end
      end
      bus.uart_write    = 1'b0;
      bus.tx_byte_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (lat < 0) begin
         errors++;
         $display("FAIL write_timeout: got no response, expected one");
      end
   endtask

   task automatic chk_tx(input logic [31:0] exp);
      logic [31:0] got;
      got = {txlog[3], txlog[2], txlog[1], txlog[0]};
      chk("tx_sequence", got, exp);
   endtask

   // ---- directed sequence ----
   initial begin
      logic [31:0] w;
      int          lat;
      int          sent;

      reset               = 1'b0;
      bus.rx_byte_valid   = 1'b0;
      bus.rx_byte         = '0;
      bus.tx_byte_ready   = 1'b1;
      bus.uart_read       = 1'b0;
      bus.uart_write      = 1'b0;
      bus.uart_write_data = '0;
      next_byte           = '0;
      tick();
      tick();
      reset = 1'b1;
      tick();

      chk("rst_rx_empty", 32'(bus.uart_rx_empty), 32'd1);
      chk("rst_tx_empty", 32'(bus.uart_tx_empty), 32'd1);
      chk("rst_tx_valid", 32'(bus.tx_byte_valid), 32'd0);
      chk("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
      chk("rst_read_data", bus.uart_read_data, 32'd0);
      chk("rst_overflow", 32'(bus.rx_overflow), 32'd0);

      // single word read, with a read held while short of bytes
      push_byte(8'h70);
      push_byte(8'h00);
      push_byte(8'h00);
      bus.uart_read = 1'b1;
      tick();
      tick();
      chk("read_waits_idle", 32'(bus.uart_tx_empty), 32'd1);
      bus.uart_read = 1'b0;
      chk("rx_empty_3", 32'(bus.uart_rx_empty), 32'd1);
      push_byte(8'h00);
      chk("rx_empty_4", 32'(bus.uart_rx_empty), 32'd0);
      do_read(1'b0, w, lat);
      chk("read1_word", w, 32'h0000_0070);
      chk("read1_latency", 32'(lat), 32'd5);
      chk("read1_rx_empty", 32'(bus.uart_rx_empty), 32'd1);

      // write, ready always high
      do_write(32'hDEAD_BEEF, 9, 0, lat, sent);
      chk("write1_sent", 32'(sent), 32'd4);
      chk_tx(32'hDEAD_BEEF);
      chk("write1_latency", 32'(lat), 32'd5);
      chk("write1_tx_empty", 32'(bus.uart_tx_empty), 32'd1);

      // write, 3 stall cycles on byte AD
      do_write(32'hDEAD_BEEF, 2, 3, lat, sent);
      chk("write2_sent", 32'(sent), 32'd4);
      chk_tx(32'hDEAD_BEEF);
      chk("write2_latency", 32'(lat), 32'd8);

      // overflow: 17 bytes into a 16-deep FIFO
      for (int b = 0; b < 16; b++) push_byte(8'(b));
      chk("ovf_before", 32'(bus.rx_overflow), 32'd0);
      push_byte(8'h10);
      chk("ovf_after", 32'(bus.rx_overflow), 32'd1);
      do_read(1'b0, w, lat);
      chk("ovf_word0", w, 32'h0302_0100);
      do_read(1'b0, w, lat);
      chk("ovf_word1", w, 32'h0706_0504);
      do_read(1'b0, w, lat);
      chk("ovf_word2", w, 32'h0B0A_0908);
      do_read(1'b0, w, lat);
      chk("ovf_word3", w, 32'h0F0E_0D0C);
      chk("ovf_rx_empty", 32'(bus.uart_rx_empty), 32'd1);

      // reset in the middle of a write with bytes buffered
      for (int b = 0; b < 6; b++) push_byte(8'h50 + 8'(b));
      bus.uart_write      = 1'b1;
      bus.uart_write_data = 32'h1122_3344;
      bus.tx_byte_ready   = 1'b1;
      tick();
      tick();
      tick();
      chk("mid_tx_valid", 32'(bus.tx_byte_valid), 32'd1);
      reset          = 1'b0;
      bus.uart_write = 1'b0;
      tick();
      chk("mrst_tx_valid", 32'(bus.tx_byte_valid), 32'd0);
      chk("mrst_rx_empty", 32'(bus.uart_rx_empty), 32'd1);
      chk("mrst_overflow", 32'(bus.rx_overflow), 32'd0);
      chk("mrst_read_data", bus.uart_read_data, 32'd0);
      chk("mrst_tx_empty", 32'(bus.uart_tx_empty), 32'd1);
      reset = 1'b1;
      tick();

      // wrap with simultaneous push/pop
      for (int b = 0; b < 14; b++) push_byte(8'h20 + 8'(b));
      next_byte = 8'h2E;
      do_read(1'b1, w, lat);
      chk("wrap_word0", w, 32'h2322_2120);
      do_read(1'b1, w, lat);
      chk("wrap_word1", w, 32'h2726_2524);
      do_read(1'b1, w, lat);
      chk("wrap_word2", w, 32'h2B2A_2928);
      chk("wrap_latency", 32'(lat), 32'd5);
      chk("wrap_overflow", 32'(bus.rx_overflow), 32'd0);
      chk("wrap_rx_empty", 32'(bus.uart_rx_empty), 32'd0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
